// File: rtl/data_mem_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the data-memory responder:
//   - responder FSM state encoding
//   - wait-state counter width, word and byte-lane widths
//   - access_err(): error rule applied to a request at its commit edge
// ---------------------------------------------------------------------------
package data_mem_pkg;

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned NUM_BYTES = WORD_W / BYTE_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // An access is rejected when it is not word aligned, falls beyond the
    // end of the RAM, or enables no byte lane at all.
    function automatic logic access_err(
        input logic [WORD_W-1:0]    addr,
        input logic [NUM_BYTES-1:0] be,
        input int unsigned          depth_words
    );
        logic [WORD_W-1:0] limit;
        limit = WORD_W'(depth_words) << 2;
        return (addr[1:0] != 2'b00) || (addr >= limit) || (be == '0);
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// ---------------------------------------------------------------------------
// dmem_byte_ram
// Synchronous single-port word RAM with per-byte write enables and a
// registered read port. Contents are never reset.
// Ports:
//   clk    in   clock, rising edge
//   en     in   access strobe for this cycle
//   we     in   1 = write enabled bytes, 0 = read only
//   addr   in   word index
//   be     in   byte-lane write enables
//   wdata  in   write data
//   rdata  out  registered read data (old contents on a write cycle),
//               held until the next enabled access
// ---------------------------------------------------------------------------
module dmem_byte_ram
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [AW-1:0]        addr,
    input  logic [NUM_BYTES-1:0] be,
    input  logic [WORD_W-1:0]    wdata,
    output logic [WORD_W-1:0]    rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                    if (be[i]) begin
                        mem_q[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
                    end
                end
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder for the processor data load/store port. Accepts one
// request at a time, waits WAIT_CYCLES cycles, commits the access to the
// byte-enabled data RAM and returns read data / write acknowledge on a
// valid/ready response channel. Misaligned, out-of-range and empty-strobe
// accesses are answered with rsp_err = 1 and no RAM update.
// Ports:
//   clk, reset          clock (rising edge), async active-high reset
//   req_valid/req_ready request handshake (req_ready only in IDLE)
//   req_we              1 = store, 0 = load
//   req_addr            byte address
//   req_wdata, req_be   store data and byte enables
//   rsp_valid/rsp_ready response handshake
//   rsp_rdata           load data; 0 for stores and errors
//   rsp_err             access error flag
//   busy                high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [WORD_W-1:0]    addr_q, addr_d;
    logic [WORD_W-1:0]    wdata_q, wdata_d;
    logic [NUM_BYTES-1:0] be_q, be_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;

    // Request as seen at the commit edge
    logic                 commit;
    logic                 c_we;
    logic [WORD_W-1:0]    c_addr;
    logic [WORD_W-1:0]    c_wdata;
    logic [NUM_BYTES-1:0] c_be;
    logic                 c_err;

    logic                 ram_en;
    logic                 ram_we;
    logic [WORD_W-1:0]    ram_rdata;

    // With WAIT_CYCLES == 0 the accept edge is also the commit edge, so the
    // live request inputs must be used because nothing is latched yet.
    always_comb begin
        commit  = 1'b0;
        c_we    = we_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        c_be    = be_q;
        if (state_q == ST_IDLE) begin
            c_we    = req_we;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_be    = req_be;
            commit  = req_valid && (WAIT_CYCLES == 0);
        end else if (state_q == ST_WAIT) begin
            commit  = (cnt_q == '0);
        end
        c_err = access_err(c_addr, c_be, DEPTH_WORDS);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    if (WAIT_CYCLES == 0) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = c_err;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = c_err;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic. The RAM read register is only strobed at the commit
    // edge, so gating it by RESP gives stable load data during back-pressure
    // and zero everywhere else.
    always_comb begin
        req_ready = (state_q == ST_IDLE) && !reset;
        busy      = (state_q != ST_IDLE);
        rsp_valid = rsp_valid_q;
        rsp_err   = rsp_err_q;
        rsp_rdata = '0;
        if ((state_q == ST_RESP) && !rsp_err_q && !we_q) begin
            rsp_rdata = ram_rdata;
        end
        ram_en = commit;
        ram_we = c_we && !c_err;
    end

    dmem_byte_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (c_addr[AW+1:2]),
        .be    (c_be),
        .wdata (c_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
// Directed bench for data_mem_responder. Instance 0 uses default parameters
// (DEPTH_WORDS 256, WAIT_CYCLES 2); instance 1 uses DEPTH_WORDS 16,
// WAIT_CYCLES 0. Expected values are hand computed.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int unsigned W0 = 2;
    localparam int unsigned W1 = 0;
    localparam int LAT_LIMIT = 20;

    logic             clk;
    logic [1:0]       reset;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_we;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0][3:0]  req_be;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [1:0][31:0] rsp_rdata;
    logic [1:0]       rsp_err;
    logic [1:0]       busy;

    int n_cmp = 0;
    int n_bad = 0;

    data_mem_responder #(
        .DEPTH_WORDS (256),
        .WAIT_CYCLES (W0)
    ) dut (
        .clk       (clk),
        .reset     (reset[0]),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_we    (req_we[0]),
        .req_addr  (req_addr[0]),
        .req_wdata (req_wdata[0]),
        .req_be    (req_be[0]),
        .rsp_valid (rsp_valid[0]),
        .rsp_ready (rsp_ready[0]),
        .rsp_rdata (rsp_rdata[0]),
        .rsp_err   (rsp_err[0]),
        .busy      (busy[0])
    );

    data_mem_responder #(
        .DEPTH_WORDS (16),
        .WAIT_CYCLES (W1)
    ) dut_w0 (
        .clk       (clk),
        .reset     (reset[1]),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_we    (req_we[1]),
        .req_addr  (req_addr[1]),
        .req_wdata (req_wdata[1]),
        .req_be    (req_be[1]),
        .rsp_valid (rsp_valid[1]),
        .rsp_ready (rsp_ready[1]),
        .rsp_rdata (rsp_rdata[1]),
        .rsp_err   (rsp_err[1]),
        .busy      (busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input int d, input string tag, input logic exp_ready);
        check_eq({tag, " rsp_valid"}, 32'(rsp_valid[d]), 32'd0);
        check_eq({tag, " rsp_rdata"}, rsp_rdata[d], 32'd0);
        check_eq({tag, " rsp_err"},   32'(rsp_err[d]), 32'd0);
        check_eq({tag, " busy"},      32'(busy[d]), 32'd0);
        check_eq({tag, " req_ready"}, 32'(req_ready[d]), 32'(exp_ready));
    endtask

    // One full transaction on instance d. Called #1 after a clock edge.
    // While the responder is busy, req_valid stays high with a conflicting
    // store to the same word; it must be ignored.
    task automatic do_txn(input int d, input string tag, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] exp_rdata,
                          input logic exp_err, input int hold);
        int lat;
        int exp_lat;
        exp_lat = (d == 0) ? int'(W0) + 1 : int'(W1) + 1;
        check_eq({tag, " ready"}, 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        @(posedge clk); #1;
        req_we[d]    = 1'b1;
        req_wdata[d] = ~wdata;
        req_be[d]    = 4'hF;
        lat = 1;
        while (!rsp_valid[d] && lat < LAT_LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, " rdata"}, rsp_rdata[d], exp_rdata);
        check_eq({tag, " err"}, 32'(rsp_err[d]), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq({tag, " hold valid"}, 32'(rsp_valid[d]), 32'd1);
            check_eq({tag, " hold rdata"}, rsp_rdata[d], exp_rdata);
            check_eq({tag, " hold err"}, 32'(rsp_err[d]), 32'(exp_err));
            check_eq({tag, " hold req_ready"}, 32'(req_ready[d]), 32'd0);
            check_eq({tag, " hold busy"}, 32'(busy[d]), 32'd1);
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
        check_eq({tag, " post valid"}, 32'(rsp_valid[d]), 32'd0);
        check_eq({tag, " post ready"}, 32'(req_ready[d]), 32'd1);
        check_eq({tag, " post busy"}, 32'(busy[d]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 2'b11;
        req_valid = '0;
        rsp_ready = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs(0, "reset0", 1'b0);
        check_idle_outputs(1, "reset1", 1'b0);
        reset = 2'b00;
        #1;
        check_eq("release ready0", 32'(req_ready[0]), 32'd1);
        check_eq("release ready1", 32'(req_ready[1]), 32'd1);
        @(posedge clk); #1;

        // Basic store/load and byte merge
        do_txn(0, "st10",     1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);
        do_txn(0, "ld10",     1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 0);
        do_txn(0, "st10_b1",  1'b1, 32'h10, 32'h0000AA00, 4'b0010, 32'h0, 1'b0, 0);
        do_txn(0, "ld10_m",   1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADAAEF, 1'b0, 0);

        // Error cases and boundaries
        do_txn(0, "st12_mis", 1'b1, 32'h12, 32'h55555555, 4'hF, 32'h0, 1'b1, 0);
        do_txn(0, "st400_oor",1'b1, 32'h400, 32'h66666666, 4'hF, 32'h0, 1'b1, 0);
        do_txn(0, "ld_be0",   1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b1, 0);
        do_txn(0, "ld10_post",1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADAAEF, 1'b0, 0);
        do_txn(0, "st3fc",    1'b1, 32'h3FC, 32'h11223344, 4'hF, 32'h0, 1'b0, 0);
        do_txn(0, "ld3fc",    1'b0, 32'h3FC, 32'h0, 4'hF, 32'h11223344, 1'b0, 0);

        // Back-pressure
        do_txn(0, "ld10_bp",  1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADAAEF, 1'b0, 5);

        // Reset during WAIT drops an uncommitted store
        do_txn(0, "st20",     1'b1, 32'h20, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 0);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'h12345678;
        req_be[0]    = 4'hF;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        check_eq("midrst busy before", 32'(busy[0]), 32'd1);
        reset[0] = 1'b1;
        #1;
        check_idle_outputs(0, "midrst", 1'b0);
        @(posedge clk); @(posedge clk); #1;
        reset[0] = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("midrst no rsp", 32'(rsp_valid[0]), 32'd0);
        end
        do_txn(0, "ld20",     1'b0, 32'h20, 32'h0, 4'hF, 32'h0BADF00D, 1'b0, 0);

        // WAIT_CYCLES == 0 instance
        do_txn(1, "w0_st04",  1'b1, 32'h04, 32'hA5A55A5A, 4'hF, 32'h0, 1'b0, 0);
        do_txn(1, "w0_ld04",  1'b0, 32'h04, 32'h0, 4'hF, 32'hA5A55A5A, 1'b0, 0);
        do_txn(1, "w0_st04b3",1'b1, 32'h04, 32'hFF000000, 4'b1000, 32'h0, 1'b0, 0);
        do_txn(1, "w0_ld04m", 1'b0, 32'h04, 32'h0, 4'hF, 32'hFFA55A5A, 1'b0, 2);
        do_txn(1, "w0_oor",   1'b0, 32'h40, 32'h0, 4'hF, 32'h0, 1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the processor's data load/store port.
- Accepts one request at a time on a valid/ready request channel and services it with a configurable number of wait states.
- Returns read data or a write acknowledge on a valid/ready response channel.
- Holds the word-organised data RAM with byte-enable writes and flags misaligned, out-of-range or empty-strobe accesses as errors.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, 16..65536.
- WAIT_CYCLES, 2, extra cycles between accept and response; 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, byte lanes aligned to the word.
- req_be  in  4  byte enables; bit i covers bits [8i+7:8i].
- rsp_valid  out  1  response available.
- rsp_ready  in  1  initiator takes the response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  access error flag.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (reset) and forces:
  - state IDLE, wait counter 0
  - rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0
  - the RAM is NOT cleared.
- FSM states IDLE, WAIT, RESP.
  - req_ready = (state == IDLE) and not reset. It is combinational from state only and never depends on req_valid.
- Accept: on a rising edge with req_valid and req_ready high, latch we, addr, wdata and be.
  - The next state is WAIT with the counter loaded to WAIT_CYCLES-1.
  - If WAIT_CYCLES == 0, the next state is RESP directly.
- WAIT: the counter decrements each cycle. At counter == 0 the next state is RESP. Requests are ignored (req_ready 0).
- Commit edge (the edge entering RESP):
  - Error check: err = (addr[1:0] != 0) or (addr >= 4*DEPTH_WORDS) or (be == 0).
  - Store with no error: only the enabled bytes of word addr[log2(DEPTH_WORDS)+1:2] are updated.
  - Load with no error: rsp_rdata = full word, ignoring be.
  - Error: no RAM write, rsp_rdata = 0, rsp_err = 1.
- Latency: rsp_valid rises exactly 1+WAIT_CYCLES cycles after the accept edge.
- RESP:
  - rsp_valid 1; rsp_rdata and rsp_err stay stable until rsp_valid and rsp_ready are both high.
  - On that handshake edge: next state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0.
  - Back-pressure of any length is legal.
- No overlap: a new request is accepted no earlier than the cycle after the response handshake. Minimum period is 2+WAIT_CYCLES cycles per transaction.
- Ordering: transactions are strictly sequential. A load after a store to the same word returns the merged store data.
- Reset mid-operation: the transaction is abandoned with no response.
  - A store not yet at its commit edge is dropped.
  - A store already committed remains in the RAM.
- Changes on request inputs while req_ready is 0 are ignored. The request is latched only at the accept edge.

Decomposition:
- Shared package data_mem_pkg contains:
  - state enum (IDLE, WAIT, RESP)
  - WAIT counter width constant (4)
  - word/byte width constants
  - error-check helper function
- One sub-module, dmem_byte_ram: synchronous single-port word RAM with 4 byte-write enables and registered read. It is instantiated once, and the FSM drives its enable at the commit edge.

Test Plan:
- Default params, after reset: store 0xDEADBEEF to 0x10 with be=1111, then load 0x10 -> rsp_valid 3 cycles after each accept, rdata=0xDEADBEEF, err=0; req_ready=1 during reset-release IDLE.
- Store 0x0000AA00 to 0x10 with be=0010, then load 0x10 -> rdata=0xDEADAAEF.
- Store to 0x12 (misaligned), store to 0x400 (out of range), load with be=0000 -> each err=1, rdata=0; a following load of 0x10 still returns 0xDEADAAEF.
- Load 0x10 with rsp_ready held low 5 cycles -> rsp_valid, rdata and err stable, req_ready=0, busy=1; on handshake -> IDLE the next cycle, req_ready=1.
- Assert reset during WAIT of a store of 0x12345678 to 0x20 -> outputs at reset values immediately; a later load of 0x20 returns the prior contents.
- Instance with WAIT_CYCLES=0: store then load 0x04 -> rsp_valid 1 cycle after each accept, rdata matches the stored data.
